l1a_chk_cfeb_sched: RTL
=======================

Name: l1a_chk_cfeb_sched

Overview:
Sequences the L1A checker across the active CFEB FIFOs of one event. It latches the active mask at header end and presents one CFEB at a time to the checker, using the CFEB_ACT/GO handshake. It supervises each CFEB with a timeout and raises EOE once every active CFEB has been serviced. The block sits between the per-CFEB FIFO status logic and the L1A checker FSM, and drives the FIFO read-select mux.

Parameters:
NCFEB, 7, number of CFEB FIFOs; legal range 1..8.
TMO_BITS, 10, width of the per-CFEB timeout counter; timeout fires at count 2**TMO_BITS-1.

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
HEADER_END  in  1  one-cycle pulse; an event header has been sent
ACT_MASK  in  NCFEB  active CFEBs for the event; sampled on HEADER_END
FIFO_MT  in  NCFEB  per-CFEB FIFO empty flags
ACT_CHK  in  1  checker is in its activity-check state (ready for the next CFEB)
STRT_TAIL  in  1  checker has started the tail
CFEB_ACT  out  1  request: the selected CFEB has data to check
GO  out  1  selected FIFO is non-empty; checker may start popping
EOE  out  1  end of event; no CFEBs remain
SEL  out  3  index of the selected CFEB (FIFO read mux select)
NEW_CFEB  out  1  one-cycle abort pulse sent to the checker on timeout
PROC_TMO  out  1  one-cycle timeout flag
PENDING  out  NCFEB  CFEBs not yet serviced
BUSY  out  1  event in progress

Behaviour:
- Reset: state IDLE. CFEB_ACT, GO, EOE, NEW_CFEB, PROC_TMO, BUSY = 0; SEL = 0; PENDING = 0; timeout counter = 0.
- All outputs are registered. An output asserts in the cycle after the condition that causes it.
- IDLE: on HEADER_END, PENDING <= ACT_MASK, BUSY <= 1, go to SCAN. No other input is looked at in IDLE.
- SCAN: wait for ACT_CHK = 1.
  - If PENDING = 0: EOE <= 1, go to TAIL.
  - Otherwise: SEL <= index of the lowest set PENDING bit (fixed ascending priority), CFEB_ACT <= 1, go to GRANT.
- GRANT: hold CFEB_ACT until ACT_CHK = 0. Then CFEB_ACT <= 0, clear the timeout counter, go to RUN.
- RUN:
  - GO = !FIFO_MT[SEL], re-registered every cycle. GO drops immediately if the FIFO goes empty.
  - The counter increments each cycle.
  - When ACT_CHK returns to 1: PENDING[SEL] <= 0, GO <= 0, go to SCAN.
  - When the counter reaches its maximum with ACT_CHK still 0: PROC_TMO and NEW_CFEB pulse for 1 cycle, PENDING[SEL] <= 0, GO <= 0, go to DRAIN.
- DRAIN: wait for ACT_CHK = 1, then go to SCAN. No new timeout is armed in DRAIN.
- TAIL: hold EOE until STRT_TAIL = 1. Then EOE <= 0, BUSY <= 0, go to IDLE.
- HEADER_END while BUSY = 1 is ignored; PENDING is not reloaded.
- ACT_MASK bits at or above NCFEB are ignored. ACT_MASK = 0 gives EOE directly after the first SCAN.
- Return to 1 and timeout in the same cycle: return to 1 wins, so no PROC_TMO is raised.
- SEL is held stable from GRANT until SCAN selects again.
- RST mid-event: immediate return to IDLE with all reset values. PENDING is lost.
- Latency: SCAN with ACT_CHK = 1 produces CFEB_ACT on the next edge.

Optional Feature:
Macro L1A_SCHED_STATS_EN.
- Defined: adds output TMO_CNT [15:0], a saturating count of PROC_TMO pulses. It resets to 0 on RST only, holds at 16'hFFFF, and is not cleared between events.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- ACT_MASK=7'b0000101, checker model returns ACT_CHK 20 cycles after GO -> SEL=0 then SEL=2; EOE rises after the second return; PENDING steps 0000101 -> 0000100 -> 0000000.
- ACT_MASK=0, then HEADER_END, ACT_CHK=1 -> EOE=1 two cycles after HEADER_END; no CFEB_ACT; EOE and BUSY drop one cycle after STRT_TAIL.
- ACT_MASK=7'b1000000, TMO_BITS=4, ACT_CHK stays 0 after GRANT -> PROC_TMO and NEW_CFEB high for exactly 1 cycle, 15 cycles after RUN entry; after ACT_CHK=1, EOE asserts.
- FIFO_MT[SEL] toggling 1,0,1 during RUN -> GO follows !FIFO_MT with 1-cycle delay.
- Second HEADER_END mid-event with ACT_MASK=7'h7F -> PENDING unchanged; only the original CFEBs are serviced.
- RST pulse during RUN -> all outputs 0 on the same edge, state IDLE; a new HEADER_END restarts normally. With L1A_SCHED_STATS_EN defined, TMO_CNT increments on each timeout and reads 0 after RST.

Source files
------------

// File: rtl/l1a_chk_cfeb_sched.sv
// Walks the active CFEB FIFOs of one event through the L1A checker, one CFEB at a time.
// Optional feature macro L1A_SCHED_STATS_EN adds TMO_CNT, a saturating count of PROC_TMO pulses.
module l1a_chk_cfeb_sched #(
  parameter int NCFEB    = 7,
  parameter int TMO_BITS = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HEADER_END,
  input  logic [NCFEB-1:0] ACT_MASK,
  input  logic [NCFEB-1:0] FIFO_MT,
  input  logic             ACT_CHK,
  input  logic             STRT_TAIL,
  output logic             CFEB_ACT,
  output logic             GO,
  output logic             EOE,
  output logic [2:0]       SEL,
  output logic             NEW_CFEB,
  output logic             PROC_TMO,
  output logic [NCFEB-1:0] PENDING,
  output logic             BUSY
`ifdef L1A_SCHED_STATS_EN
  ,
  output logic [15:0]      TMO_CNT
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_GRANT, S_RUN, S_DRAIN, S_TAIL
  } state_t;

  // The timeout decision is taken one count early so PROC_TMO lands on the
  // same edge at which the counter reaches 2**TMO_BITS-1.
  localparam logic [TMO_BITS-1:0] CNT_LAST = ~(TMO_BITS'(1));

  state_t              state_q, state_d;
  logic [NCFEB-1:0]    pend_q, pend_d;
  logic [2:0]          sel_q, sel_d;
  logic                act_q, act_d;
  logic                go_q, go_d;
  logic                eoe_q, eoe_d;
  logic                busy_q, busy_d;
  logic                tmo_q, tmo_d;
  logic                newc_q, newc_d;
  logic [TMO_BITS-1:0] cnt_q, cnt_d;

  logic [2:0]          low_idx;
  logic [NCFEB-1:0]    sel_oh;
  logic [7:0]          mt_ext;

  always_comb begin
    low_idx = '0;
    for (int i = NCFEB - 1; i >= 0; i--)
      if (pend_q[i]) low_idx = 3'(i);
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NCFEB; i++)
      sel_oh[i] = (sel_q == 3'(i));
  end

  always_comb begin
    mt_ext = '0;
    mt_ext[NCFEB-1:0] = FIFO_MT;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    act_d   = act_q;
    go_d    = go_q;
    eoe_d   = eoe_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    newc_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (HEADER_END) begin
          pend_d  = ACT_MASK;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (ACT_CHK) begin
          if (pend_q == '0) begin
            eoe_d   = 1'b1;
            state_d = S_TAIL;
          end else begin
            sel_d   = low_idx;
            act_d   = 1'b1;
            state_d = S_GRANT;
          end
        end
      end
      S_GRANT: begin
        if (!ACT_CHK) begin
          act_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        go_d  = !mt_ext[sel_q];
        // A return in the same cycle as the timeout is a normal completion.
        if (ACT_CHK) begin
          pend_d  = pend_q & ~sel_oh;
          go_d    = 1'b0;
          state_d = S_SCAN;
        end else if (cnt_q == CNT_LAST) begin
          pend_d  = pend_q & ~sel_oh;
          go_d    = 1'b0;
          tmo_d   = 1'b1;
          newc_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ACT_CHK) state_d = S_SCAN;
      end
      S_TAIL: begin
        if (STRT_TAIL) begin
          eoe_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      sel_q   <= '0;
      act_q   <= 1'b0;
      go_q    <= 1'b0;
      eoe_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      newc_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      go_q    <= go_d;
      eoe_q   <= eoe_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      newc_q  <= newc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CFEB_ACT = act_q;
  assign GO       = go_q;
  assign EOE      = eoe_q;
  assign SEL      = sel_q;
  assign NEW_CFEB = newc_q;
  assign PROC_TMO = tmo_q;
  assign PENDING  = pend_q;
  assign BUSY     = busy_q;

`ifdef L1A_SCHED_STATS_EN
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             tmo_cnt_q <= '0;
    else if (tmo_d && tmo_cnt_q != '1)   tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign TMO_CNT = tmo_cnt_q;
`endif

endmodule
